// File: rtl/rom_arbiter_pkg.sv
// Shared definitions for the two-port ROM arbiter: default widths and port IDs.
package rom_arbiter_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LD = 1'b1
  } port_id_t;

  // Map a one-hot grant vector to the granted port (only meaningful when a grant exists).
  function automatic port_id_t grant_to_id(input logic [1:0] gnt);
    return gnt[1] ? PORT_LD : PORT_IF;
  endfunction

endpackage

// File: rtl/rom_arbiter_rr_arb2.sv
// Two-request round-robin arbiter; remembers the last granted port and favours the other on a tie.
module rr_arb2
  import rom_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  port_id_t last_gnt;

  // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last_gnt == PORT_LD) ? 2'b01 : 2'b10;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_gnt <= PORT_LD;
    end else if (|gnt) begin
      last_gnt <= grant_to_id(gnt);
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Shares one synchronous-read ROM between two requesters with round-robin arbitration,
// one access per cycle, and a registered response two cycles after each grant.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout
);

  logic [1:0]        gnt;
  logic [ADDR_W-1:0] last_addr;
  logic              s1_valid;
  port_id_t          s1_id;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({req1, req0}),
    .gnt   (gnt)
  );

  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];

  // Park the ROM address on the last granted one so the ROM input stays quiet when idle.
  always_comb begin
    rom_addr = last_addr;
    if (gnt[0]) begin
      rom_addr = addr0;
    end else if (gnt[1]) begin
      rom_addr = addr1;
    end
  end

  // Stage 1: the ROM samples rom_addr at this edge; remember who asked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_addr <= '0;
      s1_valid  <= 1'b0;
      s1_id     <= PORT_IF;
    end else begin
      s1_valid <= |gnt;
      if (|gnt) begin
        last_addr <= rom_addr;
        s1_id     <= grant_to_id(gnt);
      end
    end
  end

  // Stage 2: rom_dout is valid now; steer it to the requesting port's response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= s1_valid && (s1_id == PORT_IF);
      rvalid1 <= s1_valid && (s1_id == PORT_LD);
      if (s1_valid && (s1_id == PORT_IF)) begin
        rdata0 <= rom_dout;
      end
      if (s1_valid && (s1_id == PORT_LD)) begin
        rdata1 <= rom_dout;
      end
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: reference arbiter model plus a scoreboard of expected responses.
`timescale 1ns/100ps
module tb_rom_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam logic [31:0] ROM_TAG = 32'hC0DE0000;

  typedef struct {
    int          port;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic              clk = 1'b1;
  logic              reset = 1'b1;
  logic              req0 = 1'b0, req1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic              gnt0, gnt1, rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1, rom_dout;
  logic [ADDR_W-1:0] rom_addr;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  exp_t sb[$];

  // Reference state
  bit          m_last = 1'b1;
  logic [9:0]  m_last_addr = '0;
  logic [31:0] m_rdata0 = '0, m_rdata1 = '0;

  rom_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .req0     (req0),
    .addr0    (addr0),
    .gnt0     (gnt0),
    .rvalid0  (rvalid0),
    .rdata0   (rdata0),
    .req1     (req1),
    .addr1    (addr1),
    .gnt1     (gnt1),
    .rvalid1  (rvalid1),
    .rdata1   (rdata1),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout)
  );

  always #1 clk = ~clk;

  // ROM model: synchronous read, data one cycle after the address edge.
  always @(posedge clk) rom_dout <= ROM_TAG | 32'(rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Entered at a falling edge: drive, check mid-cycle, update model, advance to next falling edge.
  task automatic step(input bit r0, input logic [9:0] a0, input bit r1, input logic [9:0] a1);
    int         g;
    logic [9:0] ea;
    bit         v0, v1;
    req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
    #0.5;
    g = -1;
    if (r0 && r1)  g = m_last ? 0 : 1;
    else if (r0)   g = 0;
    else if (r1)   g = 1;
    ea = (g == 0) ? a0 : (g == 1) ? a1 : m_last_addr;
    chk("gnt0", 32'(gnt0), 32'(g == 0));
    chk("gnt1", 32'(gnt1), 32'(g == 1));
    chk("rom_addr", 32'(rom_addr), 32'(ea));
    v0 = 1'b0; v1 = 1'b0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      if (sb[0].port == 0) begin v0 = 1'b1; m_rdata0 = sb[0].data; end
      else                 begin v1 = 1'b1; m_rdata1 = sb[0].data; end
      void'(sb.pop_front());
    end
    chk("rvalid0", 32'(rvalid0), 32'(v0));
    chk("rvalid1", 32'(rvalid1), 32'(v1));
    chk("rdata0", rdata0, m_rdata0);
    chk("rdata1", rdata1, m_rdata1);
    if (g >= 0) begin
      sb.push_back('{port: g, data: ROM_TAG | 32'(ea), due: cyc + 2});
      m_last      = (g == 1);
      m_last_addr = ea;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    // Reset state, sampled while reset is still high.
    #2.5;
    chk("rst_gnt0", 32'(gnt0), 0);
    chk("rst_gnt1", 32'(gnt1), 0);
    chk("rst_rvalid0", 32'(rvalid0), 0);
    chk("rst_rvalid1", 32'(rvalid1), 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    #0.5;
    reset = 1'b0;

    // Tie after reset: port 0 first, then strict alternation.
    for (int i = 0; i < 4; i++) step(1'b1, 10'd1, 1'b1, 10'd31);
    idle(3);

    // Single port 0 request at address 17.
    step(1'b1, 10'd17, 1'b0, '0);
    idle(3);

    // Streaming on port 1 with advancing address.
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 10'(i));
    idle(3);

    // Idle hold after a grant at 831.
    step(1'b0, '0, 1'b1, 10'h33F);
    idle(5);
    chk("hold_rdata1", rdata1, 32'hC0DE033F);
    chk("hold_rom_addr", 32'(rom_addr), 32'h33F);

    // Withdrawn request: port 1 drops req before any grant conflict, then a lone port 0.
    step(1'b1, 10'd100, 1'b1, 10'd200);
    step(1'b1, 10'd101, 1'b0, 10'd200);
    idle(3);

    // Reset mid-flight: grant port 0 at 5, reset in the next cycle.
    step(1'b1, 10'd5, 1'b0, '0);
    req0 = 1'b0; req1 = 1'b0;
    reset = 1'b1;
    #0.5;
    chk("mid_rst_rvalid0", 32'(rvalid0), 0);
    chk("mid_rst_rdata0", rdata0, 0);
    chk("mid_rst_rdata1", rdata1, 0);
    chk("mid_rst_rom_addr", 32'(rom_addr), 0);
    sb.delete();
    m_last = 1'b1; m_last_addr = '0; m_rdata0 = '0; m_rdata1 = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc += 2;
    idle(3);

    // Next tie after reset grants port 0 again.
    step(1'b1, 10'd7, 1'b1, 10'd9);
    step(1'b1, 10'd7, 1'b1, 10'd9);
    idle(4);
    chk("scoreboard_drained", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares the single synchronous-read instruction/constant ROM (1024 x 32, address sampled on clk rising edge, dout valid the following cycle) between two requesters, typically instruction fetch (port 0) and data-side load (port 1).
- Round-robin arbitration, one ROM access per cycle, fully pipelined.
- Each port sees a req/gnt handshake on the address side and a registered rvalid/rdata response two cycles after grant.

Parameters:
ADDR_W, 10, ROM word-address width (1024 words)
DATA_W, 32, ROM data width

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
req0  in  1  port 0 read request; held until gnt0
addr0  in  ADDR_W  port 0 word address; stable while req0 high
gnt0  out  1  port 0 request accepted this cycle (combinational)
rvalid0  out  1  port 0 read data valid (one-cycle pulse per grant)
rdata0  out  DATA_W  port 0 read data (registered, held between pulses)
req1, addr1, gnt1, rvalid1, rdata1  same as port 0, for port 1
rom_addr  out  ADDR_W  address to ROM addr input
rom_dout  in  DATA_W  ROM dout

Behaviour:
- Reset (async assert, sync release is the system's job): gnt0/gnt1 = 0 (no req), rvalid0/1 = 0, rdata0/1 = 0, last_addr = 0, in-flight pipeline valid bits = 0, priority pointer last_gnt = 1, so port 0 wins the first tie.
- Arbitration, combinational in cycle N:
  - only req0 → gnt0; only req1 → gnt1.
  - both → grant the port that is not last_gnt.
  - neither → no grant.
  - At most one gnt per cycle.
- rom_addr = addr of the granted port in cycle N; with no grant, rom_addr = last_addr (register updated on every grant), so the ROM input does not toggle when idle.
- Pipeline:
  - Stage 1 (end of cycle N): s1_valid <= any grant, s1_id <= granted port, last_gnt <= granted port.
  - Stage 2 (end of N+1): rom_dout is valid; when s1_valid, capture rom_dout into rdata[s1_id] and set rvalid[s1_id] = 1 for cycle N+2.
  - Latency: grant in cycle N → rvalid high in cycle N+2, exactly one cycle.
- Throughput: one grant per cycle. Back-to-back grants on alternating or same port are legal; rvalid pulses follow grant order with no reordering.
- rdata of a port changes only on that port's rvalid cycle and holds otherwise.
- Requester rules: addr must be stable while req high and not granted. Dropping req before gnt is legal and withdraws the request. No per-port outstanding limit.
- Fairness: with both ports continuously requesting, grants strictly alternate 0,1,0,1...
- A single port requesting continuously gets a grant every cycle; the pointer still updates.
- Reset mid-operation: in-flight accesses are discarded, no rvalid is produced for them after reset, and the pointer returns to last_gnt = 1.
- Address arithmetic: none. Addresses pass through unmodified; out-of-range is impossible at ADDR_W = 10.

Decomposition:
- Shared package/header: ADDR_W/DATA_W defaults, port-ID constants PORT_IF = 0 and PORT_LD = 1.
- One natural sub-module, rr_arb2: two-request round-robin arbiter holding the last_gnt pointer, with req[1:0] in and gnt[1:0] out.
- The pipeline and response registers stay in rom_arbiter.

Test Plan:
- Bench ROM model returns dout = 32'hC0DE0000 | addr one cycle after the address edge. Period 2 ns, reset high for the first 3 ns.
- Single port: req0 = 1, addr0 = 17 for one cycle → gnt0 in that cycle, rom_addr = 17, rvalid0 pulse two cycles later with rdata0 = 32'hC0DE0011. rvalid1 is never asserted.
- Tie after reset: req0 = req1 = 1, addr0 = 1, addr1 = 31, held → grants port 0, 1, 0, 1. rdata0 = 32'hC0DE0001 and rdata1 = 32'hC0DE001F on alternating rvalid pulses.
- Streaming: req1 held, addr1 = 0,1,2,3 advancing on each gnt1 → gnt1 every cycle. Four consecutive rvalid1 pulses with data ...0000 through ...0003, in order.
- Idle hold: after a grant at addr = 831 (10'h33F), deassert all reqs for 5 cycles → rom_addr stays 831, no gnt or rvalid, and rdata1 holds 32'hC0DE033F.
- Reset mid-flight: grant port 0 at addr = 5, assert reset in the next cycle → rvalid0 = 0 and rdata0 = 0 immediately, and no rvalid after release. The next tie grants port 0.
